// File: rtl/gpa_fhdo_dispatch_pkg.sv
// Shared definitions for the GPA-FHDO command dispatch block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpa_fhdo_pkg;

   // Dispatcher FSM encoding
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CAPTURE   = 3'd4
   } state_t;

   // Command word layout
   localparam int CMD_W       = 32;
   localparam int ADC_W       = 16;
   localparam int ADC_SEL_BIT = 30;
   localparam int BCAST_BIT   = 24;
   localparam int FRAME_MSB   = 23;

   // An ADC read command needs the shift register captured after the frame.
   function automatic logic is_adc_read(input logic [CMD_W-1:0] cmd);
      return cmd[ADC_SEL_BIT];
   endfunction

endpackage

// File: rtl/gpa_fhdo_dispatch_if.sv
// Bundles the command-write, SPI-issue and ADC-readback signals of the dispatcher.
// Latency: n/a (wiring only).
// Backpressure: wr_ready_o gates pushes; iface_busy_i gates issues.
// master = dispatcher side, slave = memory core / SPI interface side.
interface gpa_fhdo_dispatch_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [31:0]         wr_data_i;
   logic                wr_valid_i;
   logic                wr_ready_o;
   logic                flush_i;
   logic [31:0]         iface_data_o;
   logic                iface_valid_o;
   logic                iface_busy_i;
   logic [15:0]         iface_adc_i;
   logic [15:0]         adc_data_o;
   logic                adc_valid_o;
   logic [DEPTH_LOG2:0] fifo_level_o;
   logic                err_timeout_o;
   logic                idle_o;

   modport master (
      input  wr_data_i, wr_valid_i, flush_i, iface_busy_i, iface_adc_i,
      output wr_ready_o, iface_data_o, iface_valid_o, adc_data_o, adc_valid_o,
             fifo_level_o, err_timeout_o, idle_o
   );

   modport slave (
      output wr_data_i, wr_valid_i, flush_i, iface_busy_i, iface_adc_i,
      input  wr_ready_o, iface_data_o, iface_valid_o, adc_data_o, adc_valid_o,
             fifo_level_o, err_timeout_o, idle_o
   );
endinterface

// File: rtl/gpa_fhdo_dispatch_sync_fifo.sv
// Synchronous FIFO with occupancy level, flush and full/empty flags.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: pushes while full are dropped; flush beats push and pop.
// Ports: clk/resetn, i_flush, i_push_vld/i_push_dat, i_pop, o_head_dat,
//        o_full, o_empty, o_level.
module gpa_fhdo_sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_flush,
   input  logic                  i_push_vld,
   input  logic [WIDTH-1:0]      i_push_dat,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_head_dat,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_level
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  w_push;
   logic                  w_pop;

   assign o_full     = (r_level == FULL_LVL);
   assign o_empty    = (r_level == '0);
   assign o_level    = r_level;
   assign o_head_dat = r_mem[r_rd_ptr];

   // Pointers wrap naturally; fullness comes from the level counter.
   assign w_push = i_push_vld && !o_full && !i_flush;
   assign w_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/gpa_fhdo_dispatch.sv
// Buffers SPI command words and issues them one at a time to the GPA-FHDO SPI
// interface, tracking its busy handshake and returning ADC readback words.
// Latency: push to iface_valid_o pulse is 2 cycles when idle; ADC strobe 1 cycle after busy falls+1.
// Backpressure: wr_ready_o low when FIFO full; no issue while iface_busy_i is high.
// Ports: clk, resetn (async, active low), bus (gpa_fhdo_dispatch_if.master).
module gpa_fhdo_dispatch
   import gpa_fhdo_pkg::*;
#(
   parameter int DEPTH_LOG2   = 4,
   parameter int BUSY_TIMEOUT = 127
) (
   input  logic                  clk,
   input  logic                  resetn,
   gpa_fhdo_dispatch_if.master   bus
);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   state_t              r_state,   w_state_nxt;
   logic [CMD_W-1:0]    r_hold,    w_hold_nxt;
   logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
   logic                r_err,     w_err_nxt;
   logic [ADC_W-1:0]    r_adc,     w_adc_nxt;
   logic                r_adc_vld, w_adc_vld_nxt;

   logic                w_pop;
   logic [CMD_W-1:0]    w_head;
   logic                w_full;
   logic                w_empty;
   logic [DEPTH_LOG2:0] w_level;

   gpa_fhdo_sync_fifo #(
      .WIDTH      (CMD_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .i_flush    (bus.flush_i),
      .i_push_vld (bus.wr_valid_i),
      .i_push_dat (bus.wr_data_i),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (w_level)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_hold    <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_adc     <= '0;
         r_adc_vld <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_hold    <= w_hold_nxt;
         r_cnt     <= w_cnt_nxt;
         r_err     <= w_err_nxt;
         r_adc     <= w_adc_nxt;
         r_adc_vld <= w_adc_vld_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_hold_nxt    = r_hold;
      w_cnt_nxt     = r_cnt;
      w_err_nxt     = r_err;
      w_adc_nxt     = r_adc;
      w_adc_vld_nxt = 1'b0;
      w_pop         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A flush in the same cycle wins: the head is about to vanish.
            if (!w_empty && !bus.iface_busy_i && !bus.flush_i) begin
               w_pop       = 1'b1;
               w_hold_nxt  = w_head;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            // Busy rise lags the valid pulse by the interface clock divider.
            if (bus.iface_busy_i) begin
               w_state_nxt = ST_WAIT_DONE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_cnt_nxt == CNT_W'(BUSY_TIMEOUT)) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.iface_busy_i) begin
               w_state_nxt = is_adc_read(r_hold) ? ST_CAPTURE : ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            w_adc_nxt     = bus.iface_adc_i;
            w_adc_vld_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.wr_ready_o    = !w_full;
   assign bus.iface_valid_o = (r_state == ST_ISSUE);
   assign bus.iface_data_o  = r_hold;
   assign bus.adc_data_o    = r_adc;
   assign bus.adc_valid_o   = r_adc_vld;
   assign bus.fifo_level_o  = w_level;
   assign bus.err_timeout_o = r_err;
   assign bus.idle_o        = (r_state == ST_IDLE) && (w_level == '0);

endmodule

// File: tb/tb_gpa_fhdo_dispatch.sv
// Self-checking bench for gpa_fhdo_dispatch with a bus-functional SPI interface model.
// Latency: n/a.
// Backpressure: model pushes only when its own occupancy count says the FIFO has room.
module tb_gpa_fhdo_dispatch;
   import gpa_fhdo_pkg::*;

   localparam int DL2   = 4;
   localparam int DEPTH = 1 << DL2;
   localparam int TMO   = 127;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   gpa_fhdo_dispatch_if #(.DEPTH_LOG2(DL2)) bus ();

   gpa_fhdo_dispatch #(
      .DEPTH_LOG2   (DL2),
      .BUSY_TIMEOUT (TMO)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: words accepted but not yet issued, and ADC values owed.
   logic [31:0] mq[$];
   logic [15:0] adc_exp[$];
   logic [31:0] bfm_word = '0;
   int          n_issue = 0;
   int          n_adc = 0;
   logic [15:0] last_adc = '0;

   // Interface model controls
   bit bfm_hold  = 1'b0;
   bit bfm_never = 1'b0;
   bit bfm_fix   = 1'b0;
   bit bfm_rand  = 1'b0;
   int bfm_dly   = 3;
   int bfm_len   = 50;
   logic bfm_busy;

   assign bus.iface_busy_i = bfm_hold | bfm_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Monitor: every issue must be the oldest outstanding model word.
   initial begin : mon
      logic [31:0] w;
      logic [15:0] a;
      forever begin
         @(posedge clk); #1;
         if (bus.iface_valid_o === 1'b1) begin
            n_issue++;
            check("issue_pending", 32'(mq.size() > 0), 32'd1);
            if (mq.size() > 0) begin
               w = mq.pop_front();
               bfm_word = w;
               check("issue_data", bus.iface_data_o, w);
            end
         end
         if (bus.adc_valid_o === 1'b1) begin
            n_adc++;
            last_adc = bus.adc_data_o;
            check("adc_pending", 32'(adc_exp.size() > 0), 32'd1);
            if (adc_exp.size() > 0) begin
               a = adc_exp.pop_front();
               check("adc_data", {16'h0, bus.adc_data_o}, {16'h0, a});
            end
         end
      end
   end

   // SPI interface model: busy rises d cycles after a valid pulse, lasts l cycles.
   initial begin : bfm
      logic [31:0] w;
      logic [15:0] a;
      int d, l;
      bfm_busy = 1'b0;
      bus.iface_adc_i = '0;
      forever begin
         @(posedge clk); #2;
         if (bus.iface_valid_o === 1'b1 && !bfm_never) begin
            w = bfm_word;
            d = bfm_rand ? int'($urandom_range(0, 5)) : bfm_dly;
            l = bfm_rand ? int'($urandom_range(1, 12)) : bfm_len;
            a = bfm_fix ? 16'hBEEF : 16'($urandom);
            if (d > 0) begin
               repeat (d) @(posedge clk);
               #2;
            end
            bfm_busy = 1'b1;
            bus.iface_adc_i = a;
            if (w[ADC_SEL_BIT]) adc_exp.push_back(a);
            repeat (l) @(posedge clk);
            #2;
            bfm_busy = 1'b0;
         end
      end
   end

   task automatic push(input logic [31:0] w);
      bus.wr_data_i  = w;
      bus.wr_valid_i = 1'b1;
      check("wr_ready", 32'(bus.wr_ready_o), 32'(mq.size() < DEPTH));
      if (mq.size() < DEPTH) mq.push_back(w);
      @(posedge clk); #3;
      bus.wr_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (bus.idle_o !== 1'b1 && k < budget) begin
         @(posedge clk); #3;
         k++;
      end
      check(tag, 32'(bus.idle_o), 32'd1);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #3;
      end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_ready"},  32'(bus.wr_ready_o),    32'd1);
      check({pfx, "_idle"},   32'(bus.idle_o),        32'd1);
      check({pfx, "_valid"},  32'(bus.iface_valid_o), 32'd0);
      check({pfx, "_data"},   bus.iface_data_o,       32'd0);
      check({pfx, "_adcv"},   32'(bus.adc_valid_o),   32'd0);
      check({pfx, "_adcd"},   32'(bus.adc_data_o),    32'd0);
      check({pfx, "_level"},  32'(bus.fifo_level_o),  32'd0);
      check({pfx, "_err"},    32'(bus.err_timeout_o), 32'd0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int i0, a0, k;
      bus.wr_data_i  = '0;
      bus.wr_valid_i = 1'b0;
      bus.flush_i    = 1'b0;
      resetn         = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check_reset("rst");
      resetn = 1'b1;
      cycles(2);

      // 1: single write, busy 3 cycles after valid for 50 cycles
      bfm_dly = 3; bfm_len = 50;
      i0 = n_issue; a0 = n_adc;
      push(32'h0008_1234);
      wait_idle("t1_idle", 300);
      check("t1_issues", 32'(n_issue - i0), 32'd1);
      check("t1_adc", 32'(n_adc - a0), 32'd0);

      // 2: fill past capacity while the interface holds busy
      bfm_hold = 1'b1;
      cycles(1);
      i0 = n_issue;
      for (int i = 0; i < DEPTH + 1; i++) push($urandom);
      check("t2_level", 32'(bus.fifo_level_o), 32'(DEPTH));
      check("t2_ready", 32'(bus.wr_ready_o), 32'd0);
      bfm_rand = 1'b1;
      bfm_hold = 1'b0;
      wait_idle("t2_drain", 4000);
      check("t2_issues", 32'(n_issue - i0), 32'(DEPTH));

      // 3: ADC read returns the shift register contents
      bfm_rand = 1'b0; bfm_dly = 2; bfm_len = 10; bfm_fix = 1'b1;
      a0 = n_adc;
      push(32'h4000_0000);
      wait_idle("t3_idle", 300);
      check("t3_adc_cnt", 32'(n_adc - a0), 32'd1);
      check("t3_adc_val", {16'h0, last_adc}, 32'h0000_BEEF);
      bfm_fix = 1'b0;

      // Randomized bursts with random busy timing
      bfm_rand = 1'b1;
      for (int b = 0; b < 12; b++) begin
         int n;
         n = int'($urandom_range(1, 6));
         for (int j = 0; j < n; j++) begin
            push($urandom);
            cycles(int'($urandom_range(0, 2)));
         end
         wait_idle("rnd_idle", 2000);
         check("rnd_level", 32'(bus.fifo_level_o), 32'(mq.size()));
      end

      // 4: busy never rises -> timeout after the wait window, next word still goes
      bfm_rand = 1'b0; bfm_never = 1'b1;
      i0 = n_issue;
      push(32'h0001_0001);
      k = 0;
      while (bus.iface_valid_o !== 1'b1 && k < 10) begin
         @(posedge clk); #3;
         k++;
      end
      check("t4_valid_seen", 32'(bus.iface_valid_o), 32'd1);
      push(32'h0002_0002);
      k = 1;
      while (bus.err_timeout_o !== 1'b1 && k < 400) begin
         @(posedge clk); #3;
         k++;
      end
      check("t4_tmo_cycles", 32'(k), 32'(TMO + 1));
      bfm_never = 1'b0; bfm_dly = 2; bfm_len = 5;
      wait_idle("t4_idle", 300);
      check("t4_issues", 32'(n_issue - i0), 32'd2);
      check("t4_err_sticky", 32'(bus.err_timeout_o), 32'd1);

      // 5: flush during WAIT_DONE of word 1, with a push in the flush cycle
      bfm_dly = 2; bfm_len = 40;
      i0 = n_issue;
      for (int i = 0; i < 5; i++) push(32'h0010_0000 + 32'(i));
      k = 0;
      while (bus.iface_busy_i !== 1'b1 && k < 20) begin
         @(posedge clk); #3;
         k++;
      end
      cycles(3);
      check("t5_level_pre", 32'(bus.fifo_level_o), 32'(mq.size()));
      bus.flush_i    = 1'b1;
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 32'h0010_0006;
      @(posedge clk); #3;
      bus.flush_i    = 1'b0;
      bus.wr_valid_i = 1'b0;
      mq.delete();
      check("t5_level_post", 32'(bus.fifo_level_o), 32'd0);
      check("t5_ready", 32'(bus.wr_ready_o), 32'd1);
      wait_idle("t5_idle", 300);
      cycles(10);
      check("t5_issues", 32'(n_issue - i0), 32'd1);

      // 6: async reset while waiting for busy with 3 words queued
      bfm_never = 1'b1;
      i0 = n_issue;
      for (int i = 0; i < 4; i++) push(32'h0020_0000 + 32'(i));
      cycles(5);
      check("t6_pre_issues", 32'(n_issue - i0), 32'd1);
      resetn = 1'b0;
      #1;
      check_reset("t6_rst");
      mq.delete();
      adc_exp.delete();
      @(posedge clk); #3;
      resetn = 1'b1;
      cycles(20);
      check("t6_no_issue", 32'(n_issue - i0), 32'd1);
      bfm_never = 1'b0; bfm_dly = 1; bfm_len = 3;
      push(32'h0030_0030);
      wait_idle("t6_idle", 300);
      check("t6_issues", 32'(n_issue - i0), 32'd2);

      check("end_q", 32'(mq.size()), 32'd0);
      check("end_adc_q", 32'(adc_exp.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
